// File: rtl/arb2_sched.sv
// arb2_sched: two-requester arbiter (fixed/round-robin) with hold limit and idle/grant counters; ports clk,rst,req_a,req_b,mode,done -> gnt_a,gnt_b,busy,timeout,idle_cnt,grant_cnt
module arb2_sched #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  input  logic             mode,
  input  logic             done,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             busy,
  output logic             timeout,
  output logic [CNT_W-1:0] idle_cnt,
  output logic [CNT_W-1:0] grant_cnt
);
  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;
  state_t state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic ptr_q, ptr_d;
  logic timeout_q, timeout_d;
  logic [CNT_W-1:0] idle_q, idle_d, gcnt_q, gcnt_d;
  logic pick_b, limit, any_req, idle_st;
  always_comb begin
    idle_st = state_q == IDLE;
    any_req = req_a | req_b;
    pick_b = mode ? (req_b & (~req_a | ~ptr_q)) : ~req_a;
    limit = hold_q == 8'(MAX_HOLD - 1);
    state_d = state_q;
    ptr_d = ptr_q;
    gcnt_d = gcnt_q;
    timeout_d = 1'b0;
    hold_d = (idle_st || done || limit) ? 8'd0 : hold_q + 8'd1;
    idle_d = (idle_st && !any_req && idle_q != '1) ? idle_q + CNT_W'(1) : idle_q;
    if (idle_st) begin
      if (any_req) begin
        state_d = pick_b ? GRANT_B : GRANT_A;
        ptr_d = pick_b;
        gcnt_d = (gcnt_q != '1) ? gcnt_q + CNT_W'(1) : gcnt_q;
      end
    end else if (done || limit) begin
      state_d = IDLE;
      timeout_d = ~done;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q <= 8'd0;
      ptr_q <= 1'b1;
      timeout_q <= 1'b0;
      idle_q <= '0;
      gcnt_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      ptr_q <= ptr_d;
      timeout_q <= timeout_d;
      idle_q <= idle_d;
      gcnt_q <= gcnt_d;
    end
  end
  assign gnt_a = state_q == GRANT_A;
  assign gnt_b = state_q == GRANT_B;
  assign busy = state_q != IDLE;
  assign timeout = timeout_q;
  assign idle_cnt = idle_q;
  assign grant_cnt = gcnt_q;
endmodule

// File: tb/tb_arb2_sched.sv
// tb_arb2_sched: directed stimulus with a cycle-level owner/age model and literal checks for arb2_sched
module tb_arb2_sched;
  localparam int MH = 8;
  localparam int SAT = 15;
  logic clk = 1'b0;
  logic rst = 1'b1, req_a = 1'b0, req_b = 1'b0, mode = 1'b0, done = 1'b0;
  logic gnt_a, gnt_b, busy, timeout;
  logic [3:0] idle_cnt, grant_cnt;
  int total = 0, bad = 0;
  int m_own = 0, m_age = 0, m_last = 2, m_idle = 0, m_gcnt = 0;
  bit m_to = 1'b0, m_ok = 1'b0;
  int who, n, v;
  arb2_sched #(.MAX_HOLD(MH), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .mode(mode), .done(done),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .busy(busy), .timeout(timeout),
    .idle_cnt(idle_cnt), .grant_cnt(grant_cnt)
  );
  always #5 clk = ~clk;
  function automatic int winner();
    if (req_a && req_b) return (mode && m_last == 1) ? 2 : 1;
    return req_a ? 1 : 2;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      m_own <= 0;
      m_age <= 0;
      m_last <= 2;
      m_to <= 1'b0;
      m_idle <= 0;
      m_gcnt <= 0;
      m_ok <= 1'b1;
    end else if (m_own == 0) begin
      m_to <= 1'b0;
      if (!req_a && !req_b) m_idle <= (m_idle < SAT) ? m_idle + 1 : SAT;
      if (req_a || req_b) begin
        m_own <= winner();
        m_last <= winner();
        m_age <= 1;
        m_gcnt <= (m_gcnt < SAT) ? m_gcnt + 1 : SAT;
      end
    end else if (done) begin
      m_own <= 0;
    end else if (m_age == MH) begin
      m_own <= 0;
      m_to <= 1'b1;
    end else begin
      m_age <= m_age + 1;
    end
  end
  always @(negedge clk) begin
    if (m_ok) begin
      total = total + 1;
      if (gnt_a !== (m_own == 1) || gnt_b !== (m_own == 2) || busy !== (m_own != 0) ||
          timeout !== m_to || int'(idle_cnt) != m_idle || int'(grant_cnt) != m_gcnt) begin
        bad = bad + 1;
        $display("FAIL model t=%0t got a=%b b=%b busy=%b to=%b idle=%0d gc=%0d exp owner=%0d to=%b idle=%0d gc=%0d",
                 $time, gnt_a, gnt_b, busy, timeout, idle_cnt, grant_cnt, m_own, m_to, m_idle, m_gcnt);
      end
    end
  end
  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic check(input string name, input int act, input int exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask
  task automatic wait_gnt(output int w);
    w = 0;
    for (int i = 0; i < 20 && w == 0; i++) begin
      tick(1);
      w = gnt_a ? 1 : (gnt_b ? 2 : 0);
    end
    if (w == 0) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL wait_gnt got=no_grant exp=grant");
    end
  endtask
  initial begin
    tick(2);
    check("rst_gnt_a", gnt_a, 0);
    check("rst_gnt_b", gnt_b, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_cnt", grant_cnt, 0);
    rst = 1'b0;
    tick(20);
    check("idle_sat", idle_cnt, 15);
    do_reset();
    mode = 1'b0; req_a = 1'b1; req_b = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_gnt(who);
      check("fp_who", who, 1);
      check("fp_gcnt", grant_cnt, k + 1);
      tick(1);
      done = 1'b1;
      tick(1);
      done = 1'b0;
    end
    do_reset();
    mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(who);
      check("rr_who", who, (k % 2) ? 2 : 1);
      done = 1'b1;
      mode = 1'b0;
      tick(1);
      done = 1'b0;
      mode = 1'b1;
    end
    do_reset();
    mode = 1'b0; req_a = 1'b0; req_b = 1'b1;
    wait_gnt(who);
    check("to_who", who, 2);
    n = 1;
    for (int i = 0; i < 40 && gnt_b; i++) begin
      tick(1);
      if (gnt_b) n++;
    end
    check("to_len", n, 8);
    check("to_pulse", timeout, 1);
    tick(1);
    check("to_regrant", gnt_b, 1);
    check("to_clear", timeout, 0);
    tick(7);
    check("lim_held", gnt_b, 1);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    check("lim_release", gnt_b, 0);
    check("lim_no_to", timeout, 0);
    do_reset();
    mode = 1'b0; req_a = 1'b1; req_b = 1'b0;
    wait_gnt(who);
    check("mid_who", who, 1);
    tick(2);
    rst = 1'b1;
    tick(1);
    check("mid_gnt_a", gnt_a, 0);
    check("mid_busy", busy, 0);
    check("mid_to", timeout, 0);
    check("mid_idle", idle_cnt, 0);
    check("mid_gcnt", grant_cnt, 0);
    rst = 1'b0; req_a = 1'b0; req_b = 1'b1; mode = 1'b1;
    wait_gnt(who);
    check("mid_after_who", who, 2);
    for (int i = 0; i < 120; i++) begin
      v = (i * 29 + 7) % 16;
      req_a = v[0];
      req_b = v[1];
      mode = v[2];
      done = v[3] & v[0];
      tick(1);
    end
    req_a = 1'b0; req_b = 1'b0; done = 1'b0;
    tick(12);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule

// File: doc/arb2_sched.md
ARB2_SCHED -- requirements
Module: arb2_sched

Interface
REQ-001 Parameter MAX_HOLD, default 8, SHALL set the maximum number of consecutive cycles one grant is held; legal range 2..255.
REQ-002 Parameter CNT_W, default 8, SHALL set the width of both statistics counters.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on posedge clk.
REQ-004 Port rst, input, 1 bit, SHALL be the reset, synchronous and active-high.
REQ-005 Port req_a, input, 1 bit, SHALL be requester A's request level.
REQ-006 Port req_b, input, 1 bit, SHALL be requester B's request level.
REQ-007 Port mode, input, 1 bit, SHALL select the policy: 0 = fixed priority (A over B), 1 = round robin; sampled only in IDLE.
REQ-008 Port done, input, 1 bit, SHALL be the release strobe from the current owner.
REQ-009 Port gnt_a, output, 1 bit, SHALL be the registered grant to A.
REQ-010 Port gnt_b, output, 1 bit, SHALL be the registered grant to B.
REQ-011 Port busy, output, 1 bit, SHALL be high whenever gnt_a or gnt_b is high.
REQ-012 Port timeout, output, 1 bit, SHALL be a one-cycle pulse on a forced release.
REQ-013 Port idle_cnt, output, CNT_W bits, SHALL count IDLE cycles with req_a=0 and req_b=0.
REQ-014 Port grant_cnt, output, CNT_W bits, SHALL count grants issued.

Function
REQ-015 FSM states SHALL be IDLE, GRANT_A, GRANT_B; gnt_a=1 only in GRANT_A, gnt_b=1 only in GRANT_B, never both.
REQ-016 In IDLE, a posedge sampling any request SHALL move to a GRANT state, grant visible the next cycle (1-cycle latency).
REQ-017 mode=0: req_a=1 -> GRANT_A; else req_b=1 -> GRANT_B.
REQ-018 mode=1: single requester wins; both requesting -> the requester not granted last; last-grant pointer resets to B (A wins first tie).
REQ-019 Last-grant pointer SHALL update on every grant in both modes.
REQ-020 Hold counter SHALL clear on grant entry and increment each cycle in a GRANT state.
REQ-021 done=1 sampled in a GRANT state SHALL return to IDLE; grant deasserts next cycle.
REQ-022 Hold counter reaching MAX_HOLD-1 with done=0 SHALL return to IDLE and pulse timeout in the cycle the grant deasserts; so a grant lasts at most MAX_HOLD cycles.
REQ-023 done and the MAX_HOLD limit coinciding SHALL be a normal release, no timeout.
REQ-024 After every release at least one IDLE cycle (both grants low) SHALL occur before the next grant.
REQ-025 Request deassertion during a grant SHALL be ignored; only done or timeout releases.
REQ-026 done in IDLE SHALL be ignored.
REQ-027 idle_cnt and grant_cnt SHALL saturate at all-ones, never wrap.
REQ-028 grant_cnt SHALL increment on the IDLE->GRANT transition edge.

Reset
REQ-029 rst=1 at a posedge SHALL force IDLE, gnt_a=gnt_b=busy=timeout=0, hold counter=0, pointer=B, idle_cnt=0, grant_cnt=0, overriding all other inputs, including mid-grant.
REQ-030 The first cycle after rst deasserts SHALL be evaluated as IDLE; idle_cnt counts no cycle with rst=1.

Verification
REQ-031 mode=0, req_a=req_b=1 held, done pulsed on each grant's 2nd cycle -> every grant is gnt_a, one idle cycle between, grant_cnt increments by 1 per grant.
REQ-032 mode=1, req_a=req_b=1 held, done on each grant's 1st cycle -> grants alternate A,B,A,B starting with A after reset.
REQ-033 req_b=1, done=0 held, MAX_HOLD=8 -> gnt_b high exactly 8 cycles, timeout pulses 1 cycle as gnt_b falls, re-grant to B after 1 idle cycle.
REQ-034 done asserted on the 8th grant cycle (MAX_HOLD=8) -> release with timeout=0.
REQ-035 rst asserted on 3rd cycle of GRANT_A -> next cycle all outputs 0, counters 0; after rst release with req_b=1, mode=1 -> gnt_b.
REQ-036 CNT_W=4, no requests for 20 cycles -> idle_cnt reaches 15 and holds at 15.
